// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, constants and buffer entry type for the fetch stage
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;
  localparam int CNT_W = 8;
  typedef struct packed {
    logic [31:0] addr;
    logic [INSTR_W-1:0] data;
    logic filled;
  } entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory req/gnt/rvalid bus
interface instr_fetch_unit_if;
  logic req;
  logic [31:0] addr;
  logic gnt;
  logic rvalid;
  logic [fetch_pkg::INSTR_W-1:0] rdata;
  modport master(output req, addr, input gnt, rvalid, rdata);
  modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order queue of fetched words, allocated at grant and filled at response
module fetch_buffer import fetch_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic alloc,
  input  logic [31:0] alloc_addr,
  input  logic fill,
  input  logic [INSTR_W-1:0] fill_data,
  input  logic pop,
  output logic [$clog2(DEPTH):0] count,
  output entry_t head
);
  localparam int PW = $clog2(DEPTH);
  entry_t ent [DEPTH];
  logic [PW-1:0] hd, tl, fp;
  assign head = ent[hd];
  // Filled entries always form a prefix of the queue, so fp tracks the oldest pending one
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      hd <= '0;
      tl <= '0;
      fp <= '0;
      count <= '0;
    end else begin
      if (alloc) begin
        ent[tl] <= '{addr: alloc_addr, data: NOP_INSTR, filled: 1'b0};
        tl <= tl + PW'(1);
      end
      if (fill) begin
        ent[fp].data <= fill_data;
        ent[fp].filled <= 1'b1;
        fp <= fp + PW'(1);
      end
      hd <= pop ? hd + PW'(1) : hd;
      count <= count + (PW+1)'(alloc) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, fetch issue, response accounting and decode handoff
module instr_fetch_unit import fetch_pkg::*; #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int BUF_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  instr_fetch_unit_if.master imem,
  input  logic redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic halt,
  input  logic stall,
  output logic instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0] instr_pc
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  logic [31:0] pc;
  logic halted;
  logic [CW-1:0] outstanding, count;
  logic [CNT_W-1:0] drop_cnt;
  entry_t head;
  logic grant, resp_drop, resp_fill, pop;
  assign imem.req = rst_n & ~halted & ~halt & (count < CW'(BUF_DEPTH));
  assign imem.addr = pc;
  assign grant = imem.req & imem.gnt;
  assign resp_drop = imem.rvalid & (drop_cnt != '0);
  assign resp_fill = imem.rvalid & (drop_cnt == '0) & (outstanding != '0);
  assign instr_valid = (count != '0) & head.filled;
  assign instruction = instr_valid ? head.data : NOP_INSTR;
  assign instr_pc = instr_valid ? head.addr : 32'h0;
  assign pop = instr_valid & ~stall & ~redirect_valid;
  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .alloc(grant),
    .alloc_addr(pc),
    .fill(resp_fill),
    .fill_data(imem.rdata),
    .pop(pop),
    .count(count),
    .head(head)
  );
  // A redirect turns every in-flight request, including one granted now, into a response to drop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
      halted <= 1'b0;
    end else begin
      halted <= halted | halt;
      if (redirect_valid) begin
        pc <= redirect_pc & ~32'h3;
        outstanding <= '0;
        drop_cnt <= drop_cnt + CNT_W'(outstanding) + CNT_W'(grant) - CNT_W'(resp_drop | resp_fill);
      end else begin
        pc <= grant ? pc + 32'd4 : pc;
        outstanding <= outstanding + CW'(grant) - CW'(resp_fill);
        drop_cnt <= drop_cnt - CNT_W'(resp_drop);
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: random and directed fetch traffic checked against a queue-based model
module tb_instr_fetch_unit;
  import fetch_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redirect_valid = 1'b0;
  logic halt = 1'b0;
  logic stall = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic instr_valid;
  logic [31:0] instruction, instr_pc;
  always #5 clk = ~clk;
  instr_fetch_unit_if imem();
  instr_fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem(imem),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .stall(stall),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .instr_pc(instr_pc)
  );
  typedef struct {logic [31:0] addr; logic [31:0] data; bit filled;} ment_t;
  typedef struct {logic [31:0] addr; int ep; int ready;} mreq_t;
  ment_t mq[$];
  mreq_t memq[$];
  logic [31:0] m_pc = 32'h0;
  bit m_halted = 1'b0;
  bit late_pending = 1'b0;
  int epoch = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step(input bit r_n, input bit st, input bit rd, input logic [31:0] rp, input bit h, input bit g, input int lat);
    bit ereq, ev, rv, late;
    logic [31:0] rdat;
    mreq_t r;
    @(negedge clk);
    rv = 1'b0;
    late = 1'b0;
    rdat = '0;
    if (r_n && late_pending) begin
      rv = 1'b1;
      late = 1'b1;
      rdat = 32'hDEAD_BEEF;
      g = 1'b0;
      late_pending = 1'b0;
    end else if (r_n && memq.size() > 0 && memq[0].ready <= cyc) begin
      rv = 1'b1;
      rdat = memq[0].addr + 32'h1000;
    end
    rst_n = r_n;
    stall = st;
    redirect_valid = rd;
    redirect_pc = rp;
    halt = h;
    imem.gnt = g;
    imem.rvalid = rv;
    imem.rdata = rdat;
    #1;
    ereq = r_n && !m_halted && !h && mq.size() < DEPTH;
    ev = mq.size() > 0 && mq[0].filled;
    check("imem_req", 32'(imem.req), 32'(ereq));
    check("imem_addr", imem.addr, m_pc);
    check("instr_valid", 32'(instr_valid), 32'(ev));
    check("instruction", instruction, ev ? mq[0].data : NOP_INSTR);
    if (ev) check("instr_pc", instr_pc, mq[0].addr);
    @(posedge clk);
    if (!r_n) begin
      mq.delete();
      memq.delete();
      m_pc = 32'h0;
      m_halted = 1'b0;
      epoch++;
      late_pending = 1'b1;
    end else begin
      if (rv && !late) begin
        r = memq.pop_front();
        if (r.ep == epoch && !rd) begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              mq[i].filled = 1'b1;
              mq[i].data = rdat;
              break;
            end
          end
        end
      end
      if (ereq && g) memq.push_back('{m_pc, epoch, cyc + lat});
      if (rd) begin
        mq.delete();
        epoch++;
        m_pc = rp & ~32'h3;
      end else begin
        if (ev && !st) void'(mq.pop_front());
        if (ereq && g) begin
          mq.push_back('{m_pc, 32'h0, 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      m_halted = m_halted | h;
    end
    cyc++;
  endtask
  initial begin
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata = '0;
    repeat (2) step(0, 0, 0, 0, 0, 0, 1);
    repeat (12) step(1, 0, 0, 0, 0, 1, 1);
    repeat (3) step(1, 1, 0, 0, 0, 1, 1);
    repeat (6) step(1, 0, 0, 0, 0, 1, 1);
    repeat (4) step(1, 0, 0, 0, 0, 0, 1);
    repeat (6) step(1, 0, 0, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0, 0, 1, 3);
    step(1, 0, 1, 32'h403, 0, 1, 1);
    repeat (10) step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 1, 32'hFFFF_FFF9, 0, 1, 1);
    repeat (8) step(1, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 600; i++)
      step(1, $urandom_range(3) == 0, $urandom_range(19) == 0,
           ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom,
           0, $urandom_range(9) < 7, $urandom_range(3, 1));
    repeat (4) step(1, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1, 1);
    repeat (10) step(1, $urandom_range(1), 0, 0, 0, 1, $urandom_range(3, 1));
    step(1, 0, 1, 32'h800, 0, 1, 1);
    repeat (5) step(1, 0, 0, 0, 0, 1, 1);
    repeat (3) step(1, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1);
    repeat (10) step(1, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 800; i++)
      step($urandom_range(49) != 0, $urandom_range(3) == 0, $urandom_range(24) == 0, $urandom,
           $urandom_range(99) == 0, $urandom_range(9) < 6, $urandom_range(4, 1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
